// File: rtl/cute_key_sequencer_if.sv
// Key-schedule load channel between the provisioning logic and
// cute_key_sequencer. One beat carries one key word; the beat is accepted
// on a cycle where load_valid & load_ready.
//   load_valid : beat valid (provisioning -> sequencer)
//   load_ready : sequencer can take a beat (sequencer -> provisioning)
//   load_data  : key word for the current slot
//   load_last  : final beat of a schedule
//   load_par   : even-parity bit over {load_par, load_data}, present only
//                when KEYSEQ_PARITY_EN is defined
interface cute_key_sequencer_if #(
  parameter int unsigned KEY_W = 3
);
  logic             load_valid;
  logic             load_ready;
  logic [KEY_W-1:0] load_data;
  logic             load_last;
`ifdef KEYSEQ_PARITY_EN
  logic             load_par;
`endif

  modport master (
    output load_valid,
    output load_data,
    output load_last,
`ifdef KEYSEQ_PARITY_EN
    output load_par,
`endif
    input  load_ready
  );

  modport slave (
    input  load_valid,
    input  load_data,
    input  load_last,
`ifdef KEYSEQ_PARITY_EN
    input  load_par,
`endif
    output load_ready
  );
endinterface

// File: rtl/cute_key_sequencer.sv
// Key sequencer for a Cute-Lock counter-selected locked core.
// Stores DEPTH key words (one per core counter state), loaded over the
// load channel. On start it pulses core_rst_n low for one cycle so the core
// counter and the local phase counter both start at zero, then drives
// keyinput = mem[phase] every cycle until stop.
// Optional feature: define KEYSEQ_PARITY_EN to add load_par and an even
// parity check on every accepted beat.
// Ports:
//   clock, reset_n : clock shared with the core, async active-low reset
//   load           : key-word load channel (slave side)
//   start, stop    : run control (start sampled in ARMED, stop in ARMED/RUN)
//   core_rst_n     : registered active-low reset to the locked core
//   keyinput       : registered key word to the core
//   phase          : current schedule slot, mirrors the core counter
//   busy           : high while keys are being driven
//   loaded         : a complete schedule is stored
//   err            : sticky load error, cleared by the next accepted beat
module cute_key_sequencer #(
  parameter int unsigned KEY_W = 3,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 2
) (
  input  logic                clock,
  input  logic                reset_n,
  cute_key_sequencer_if.slave load,
  input  logic                start,
  input  logic                stop,
  output logic                core_rst_n,
  output logic [KEY_W-1:0]    keyinput,
  output logic [CNT_W-1:0]    phase,
  output logic                busy,
  output logic                loaded,
  output logic                err
);

  typedef enum logic [2:0] {IDLE, LOAD, ARMED, SYNC, RUN} state_t;

  localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(DEPTH - 1);

  state_t           state_q, state_d;
  logic [KEY_W-1:0] mem [DEPTH];
  logic [CNT_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] slot, phase_inc, phase_d;
  logic [KEY_W-1:0] keyinput_d;
  logic             loaded_d, err_d, core_rst_n_d, busy_d;
  logic             ready, accept, par_ok, mem_we;

  assign ready          = (state_q == IDLE) || (state_q == LOAD) || (state_q == ARMED);
  assign load.load_ready = ready;
  assign accept         = load.load_valid & ready;

  // A beat taken outside LOAD always opens a new schedule at slot 0.
  assign slot      = (state_q == LOAD) ? wr_ptr_q : '0;
  assign phase_inc = (phase == LAST_SLOT) ? '0 : phase + CNT_W'(1);

`ifdef KEYSEQ_PARITY_EN
  assign par_ok = ~(^{load.load_par, load.load_data});
`else
  assign par_ok = 1'b1;
`endif

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    loaded_d     = loaded;
    err_d        = err;
    core_rst_n_d = 1'b1;
    busy_d       = 1'b0;
    phase_d      = '0;
    keyinput_d   = '0;
    mem_we       = 1'b0;

    case (state_q)
      IDLE, LOAD, ARMED: begin
        if (accept) begin
          // Every accepted beat clears err and invalidates the old schedule;
          // only a correctly terminated schedule re-arms.
          err_d    = 1'b0;
          loaded_d = 1'b0;
          wr_ptr_d = '0;
          if (!par_ok) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end else begin
            mem_we = 1'b1;
            if (slot == LAST_SLOT) begin
              if (load.load_last) begin
                loaded_d = 1'b1;
                state_d  = ARMED;
              end else begin
                err_d   = 1'b1;
                state_d = IDLE;
              end
            end else if (load.load_last) begin
              err_d   = 1'b1;
              state_d = IDLE;
            end else begin
              wr_ptr_d = slot + CNT_W'(1);
              state_d  = LOAD;
            end
          end
        end else if (state_q == ARMED && start && !stop) begin
          state_d      = SYNC;
          core_rst_n_d = 1'b0;
        end
      end
      SYNC: begin
        state_d = RUN;
        busy_d  = 1'b1;
      end
      RUN: begin
        if (stop) begin
          state_d = ARMED;
        end else begin
          busy_d  = 1'b1;
          phase_d = phase_inc;
        end
      end
      default: state_d = IDLE;
    endcase

    // Key word is looked up from the next phase and registered, so the
    // wrap from DEPTH-1 to 0 changes keyinput cleanly on the clock edge.
    if (busy_d) keyinput_d = mem[phase_d];
  end

  always_ff @(posedge clock) begin
    if (mem_we) mem[slot] <= load.load_data;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      loaded     <= 1'b0;
      err        <= 1'b0;
      core_rst_n <= 1'b0;
      busy       <= 1'b0;
      phase      <= '0;
      keyinput   <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      loaded     <= loaded_d;
      err        <= err_d;
      core_rst_n <= core_rst_n_d;
      busy       <= busy_d;
      phase      <= phase_d;
      keyinput   <= keyinput_d;
    end
  end

endmodule

// File: tb/tb_cute_key_sequencer.sv
// Bench for cute_key_sequencer: directed test-plan sequences plus random
// load/run traffic. Expected key/phase pairs are queued when a run is
// requested and popped by a monitor whenever busy is high.
module tb_cute_key_sequencer;
  localparam int unsigned KEY_W = 3;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = 2;
`ifdef KEYSEQ_PARITY_EN
  localparam bit PARITY_ON = 1'b1;
`else
  localparam bit PARITY_ON = 1'b0;
`endif

  logic             clock = 1'b0;
  logic             reset_n = 1'b0;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic             core_rst_n, busy, loaded, err;
  logic [KEY_W-1:0] keyinput;
  logic [CNT_W-1:0] phase;

  cute_key_sequencer_if #(.KEY_W(KEY_W)) bus ();

  cute_key_sequencer #(.KEY_W(KEY_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .load       (bus),
    .start      (start),
    .stop       (stop),
    .core_rst_n (core_rst_n),
    .keyinput   (keyinput),
    .phase      (phase),
    .busy       (busy),
    .loaded     (loaded),
    .err        (err)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [KEY_W-1:0] key;
    logic [CNT_W-1:0] ph;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model of the schedule store
  logic [KEY_W-1:0] sched [DEPTH];
  logic [KEY_W-1:0] pend  [DEPTH];
  int               pos = 0;
  bit               m_loaded = 1'b0;
  bit               m_err = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // A schedule is good only if exactly DEPTH beats arrive and the last one
  // (and only that one) carries load_last; any other shape is an error.
  function automatic void model_beat(input logic [KEY_W-1:0] d, input bit last, input bit par_bad);
    m_err    = 1'b0;
    m_loaded = 1'b0;
    if (PARITY_ON && par_bad) begin
      m_err = 1'b1;
      pos   = 0;
      return;
    end
    pend[pos] = d;
    if (pos == DEPTH - 1 && last) begin
      m_loaded = 1'b1;
      for (int i = 0; i < DEPTH; i++) sched[i] = pend[i];
      pos = 0;
    end else if (pos == DEPTH - 1 || last) begin
      m_err = 1'b1;
      pos   = 0;
    end else begin
      pos++;
    end
  endfunction

  task automatic send_beat(input logic [KEY_W-1:0] d, input bit last, input bit par_bad);
    int n = 0;
    @(posedge clock); #1;
    bus.load_valid = 1'b1;
    bus.load_data  = d;
    bus.load_last  = last;
`ifdef KEYSEQ_PARITY_EN
    bus.load_par   = (^d) ^ par_bad;
`endif
    while (!bus.load_ready && n < 20) begin
      @(posedge clock); #1;
      n++;
    end
    check("load_ready_wait", bus.load_ready, 1);
    @(posedge clock); #1;
    bus.load_valid = 1'b0;
    bus.load_last  = 1'b0;
    model_beat(d, last, par_bad);
    check("err", err, m_err);
    check("loaded", loaded, m_loaded);
  endtask

  task automatic load_full();
    for (int i = 0; i < DEPTH; i++)
      send_beat(KEY_W'($urandom_range(0, (1 << KEY_W) - 1)), i == DEPTH - 1, 1'b0);
  endtask

  // Start, let busy stay high for n cycles, then stop.
  task automatic run_for(input int n);
    for (int k = 0; k < n; k++) q.push_back('{key: sched[k % DEPTH], ph: CNT_W'(k % DEPTH)});
    @(posedge clock); #1;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    check("sync_core_rst_n", core_rst_n, 0);
    check("sync_busy", busy, 0);
    repeat (n) @(posedge clock);
    #1;
    stop = 1'b1;
    @(posedge clock); #1;
    stop = 1'b0;
    check("stop_busy", busy, 0);
    check("stop_keyinput", keyinput, 0);
    check("stop_loaded_kept", loaded, 1);
    check("run_drain", q.size(), 0);
  endtask

  // Start that must not take effect (not loaded, or stop held with it).
  task automatic try_start(input bit stop_too);
    @(posedge clock); #1;
    start = 1'b1;
    stop  = stop_too;
    @(posedge clock); #1;
    start = 1'b0;
    stop  = 1'b0;
    check("nostart_busy", busy, 0);
    check("nostart_core_rst_n", core_rst_n, 1);
    @(posedge clock); #1;
    check("nostart_busy2", busy, 0);
    check("nostart_loaded", loaded, m_loaded);
  endtask

  task automatic reset_mid_run(input int n, input int k);
    for (int j = 0; j < n; j++) q.push_back('{key: sched[j % DEPTH], ph: CNT_W'(j % DEPTH)});
    @(posedge clock); #1;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (k) @(posedge clock);
    #2;
    check("prereset_busy", busy, 1);
    reset_n = 1'b0;
    #1;
    check("arst_keyinput", keyinput, 0);
    check("arst_loaded", loaded, 0);
    check("arst_core_rst_n", core_rst_n, 0);
    check("arst_busy", busy, 0);
    check("arst_phase", phase, 0);
    q.delete();
    m_loaded = 1'b0;
    m_err    = 1'b0;
    pos      = 0;
    @(negedge clock); #2;
    reset_n = 1'b1;
    @(posedge clock); #1;
    check("rel_load_ready", bus.load_ready, 1);
    check("rel_core_rst_n", core_rst_n, 1);
    check("rel_err", err, 0);
  endtask

  always @(negedge clock) begin : monitor
    exp_t e;
    if (reset_n) begin
      if (busy) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL busy_unexpected actual=busy required=idle at %0t", $time);
        end else begin
          e = q.pop_front();
          check("run_keyinput", keyinput, e.key);
          check("run_phase", phase, e.ph);
          check("run_core_rst_n", core_rst_n, 1);
        end
      end else begin
        check("idle_keyinput", keyinput, 0);
        check("idle_phase", phase, 0);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.load_valid = 1'b0;
    bus.load_data  = '0;
    bus.load_last  = 1'b0;
`ifdef KEYSEQ_PARITY_EN
    bus.load_par   = 1'b0;
`endif
    #3;
    check("rst_load_ready", bus.load_ready, 1);
    check("rst_keyinput", keyinput, 0);
    check("rst_phase", phase, 0);
    check("rst_busy", busy, 0);
    check("rst_loaded", loaded, 0);
    check("rst_err", err, 0);
    check("rst_core_rst_n", core_rst_n, 0);
    #19;
    reset_n = 1'b1;
    @(posedge clock); #1;
    check("release_core_rst_n", core_rst_n, 1);

    // Schedule 5,3,6,1 and a run that wraps
    send_beat(3'd5, 1'b0, 1'b0);
    send_beat(3'd3, 1'b0, 1'b0);
    send_beat(3'd6, 1'b0, 1'b0);
    send_beat(3'd1, 1'b1, 1'b0);
    run_for(6);
    // Stop at phase 2, restart from phase 0
    run_for(3);
    run_for(2);
    // start and stop together in ARMED
    try_start(1'b1);

    // Short schedule, then ignored start
    send_beat(3'd2, 1'b0, 1'b0);
    send_beat(3'd4, 1'b1, 1'b0);
    try_start(1'b0);
    // Overlong schedule (no last on the final slot)
    for (int i = 0; i < DEPTH; i++) send_beat(KEY_W'(i + 1), 1'b0, 1'b0);
    try_start(1'b0);
    load_full();
    run_for(5);

`ifdef KEYSEQ_PARITY_EN
    send_beat(3'd3, 1'b0, 1'b1);
    try_start(1'b0);
    load_full();
    run_for(4);
`endif

    for (int it = 0; it < 30; it++) begin
      case ($urandom_range(0, 5))
        0, 1: load_full();
        2: begin
          int len;
          len = $urandom_range(1, DEPTH);
          for (int i = 0; i < len; i++)
            send_beat(KEY_W'($urandom_range(0, (1 << KEY_W) - 1)),
                      (len < DEPTH) && (i == len - 1), 1'b0);
        end
        3: if (m_loaded) run_for($urandom_range(1, 10)); else try_start(1'b0);
        4: try_start(!m_loaded ? 1'b0 : 1'b1);
        default: begin
          if (PARITY_ON)
            send_beat(KEY_W'($urandom_range(0, (1 << KEY_W) - 1)), 1'b0, 1'b1);
          else if (m_loaded)
            run_for($urandom_range(1, 10));
          else
            load_full();
        end
      endcase
    end

    if (!m_loaded) load_full();
    reset_mid_run(6, 2);
    try_start(1'b0);
    load_full();
    run_for(4);

    @(posedge clock); #1;
    check("queue_empty_end", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cute_key_sequencer.md
# cute_key_sequencer

Controller that drives the key inputs of a Cute-Lock structurally locked ITC99 core (counter-selected key muxes, e.g. the locked b01). It stores one key word per core counter state, loaded over a valid/ready interface. On start it resets the locked core so both counters begin at zero, then presents the key word matching the core's internal counter phase on every cycle. It sits between the key-provisioning logic and the `keyinput*` pins of the locked core.

## Interface
- `KEY_W`, default 3: width of one key word; equals the number of `keyinput` pins on the core.
- `DEPTH`, default 4: number of core counter states, i.e. key words per schedule. Legal range 2..16.
- `CNT_W`, default 2: phase counter width, equal to clog2(`DEPTH`).

Ports:
- `clock`  in  1: rising-edge clock, shared with the locked core.
- `reset_n`  in  1: asynchronous, active-low reset.
- `load_valid`  in  1: key word beat valid.
- `load_ready`  out  1: beat accepted on a cycle where `load_valid` & `load_ready`.
- `load_data`  in  `KEY_W`: key word for the current slot.
- `load_last`  in  1: marks the final beat of a schedule.
- `start`  in  1: begin driving keys (sampled in ARMED only).
- `stop`  in  1: stop driving keys (sampled in RUN and ARMED).
- `core_rst_n`  out  1: registered active-low reset to the locked core.
- `keyinput`  out  `KEY_W`: registered key word to the core.
- `phase`  out  `CNT_W`: current schedule slot, mirrors the core counter.
- `busy`  out  1: high in RUN.
- `loaded`  out  1: a complete schedule is stored.
- `err`  out  1: sticky load error. Cleared by the next accepted beat.

## Operation
- States:
  - IDLE: `load_ready`=1.
  - LOAD: `load_ready`=1.
  - ARMED: `load_ready`=1.
  - SYNC: one cycle.
  - RUN: `load_ready`=0.
- Storage: `DEPTH` x `KEY_W` register array. Write pointer `wr_ptr` starts at 0.
- IDLE/ARMED to LOAD: the first accepted beat writes slot 0, clears `loaded`, sets `wr_ptr`=1.
- LOAD: each accepted beat writes slot `wr_ptr` and increments it.
  - Beat with `load_last` at `wr_ptr`==`DEPTH`-1: sets `loaded`, goes to ARMED.
  - `load_last` early (short schedule): sets `err`, clears `loaded`, goes to IDLE.
  - Missing `load_last` on beat `DEPTH`-1 (overlong schedule): sets `err`, goes to IDLE.
- ARMED:
  - `start` & !`stop`: go to SYNC.
  - `start` & `stop` together: stay in ARMED (stop wins).
- SYNC: `core_rst_n`=0 for exactly one cycle, `keyinput`=0, `phase`=0. Next state RUN.
- RUN:
  - `keyinput`=mem[`phase`].
  - `phase` increments each cycle, wrapping `DEPTH`-1 to 0.
  - `stop`: return to ARMED. `keyinput` and `phase` become 0, the stored schedule is kept.
- `start` in IDLE or LOAD: ignored. `load_valid` in RUN/SYNC: not accepted.
- Outside RUN, `keyinput`=0.

## Timing
- Reset values:
  - State IDLE, `load_ready`=1.
  - `keyinput`=0, `phase`=0, `busy`=0, `loaded`=0, `err`=0.
  - `core_rst_n`=0 while `reset_n` is low; `core_rst_n`=1 from the first edge after release.
- Outputs are registered.
- Start latency:
  - `start` sampled at edge t.
  - `core_rst_n`=0 in cycle t..t+1.
  - In cycle t+1..t+2: `busy`=1, `phase`=0, `keyinput`=mem[0].
  - In the following cycle: `phase`=1.
- Stop latency: `stop` sampled at edge t, so `busy`=0 and `keyinput`=0 after edge t.
- `reset_n` asserted mid-RUN or mid-LOAD: immediate asynchronous return to reset values. The stored schedule is invalidated (`loaded`=0).
- Phase arithmetic: modulo `DEPTH`. The wrap must not glitch `keyinput`.

## Configuration
- `KEYSEQ_PARITY_EN` defined:
  - Adds input `load_par` (1 bit).
  - Each accepted beat requires even parity over {`load_par`, `load_data`}.
  - On mismatch: `err`=1, `loaded`=0, the beat is discarded, state goes to IDLE.
- `KEYSEQ_PARITY_EN` undefined: `load_par` is absent and no check is made.

## Test plan
- Load 5,3,6,1 (last on the 4th beat), then `start` → one cycle of `core_rst_n`=0, then `keyinput` sequence 5,3,6,1,5,3… with `phase` 0,1,2,3,0,1.
- Load 2 beats with `load_last` on beat 2 → `err`=1, `loaded`=0, state IDLE; a `start` pulse is ignored (`busy` stays 0).
- In RUN at `phase`=2 assert `stop` → next cycle `busy`=0, `keyinput`=0; re-`start` → `phase` restarts at 0 with `keyinput`=5.
- `start` and `stop` asserted together in ARMED → `busy` stays 0, `core_rst_n` stays 1.
- `reset_n` pulled low mid-RUN → `keyinput`=0, `loaded`=0, `core_rst_n`=0 asynchronously; after release, `load_ready`=1.
- With `KEYSEQ_PARITY_EN`: beat `load_data`=3, `load_par`=1 → `err`=1, state IDLE; a correct 4-beat reload clears `err` and sets `loaded`=1.
